// File: rtl/exe_muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldivPkg;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldivOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdState_t;

endpackage

// File: rtl/exe_muldiv_divcore.sv
// Unsigned restoring divider: one quotient bit per step, DIV_ITERS steps per divide.
module divCore
  import muldivPkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         last_o,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] quot_q, quot_d;
  logic [W-1:0] dvsr_q, dvsr_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [W:0]   partial;

  always_comb begin
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    // Partial remainder can reach W+1 bits before the trial subtraction.
    partial = {rem_q, quot_q[W-1]};
    if (load_i) begin
      rem_d  = '0;
      quot_d = dividend_i;
      dvsr_d = divisor_i;
      cnt_d  = 5'(DIV_ITERS - 1);
    end else if (step_i) begin
      cnt_d = cnt_q - 5'd1;
      if (partial >= {1'b0, dvsr_q}) begin
        rem_d  = W'(partial - {1'b0, dvsr_q});
        quot_d = {quot_q[W-2:0], 1'b1};
      end else begin
        rem_d  = partial[W-1:0];
        quot_d = {quot_q[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last_o = (cnt_q == 5'd0);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/exe_muldiv.sv
// RV32M execute-stage unit: single-cycle multiply, iterative divide/remainder
// with special-case shortcuts and sign fix-up.
module exe_muldiv
  import muldivPkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdState_t        state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            rem_sel_q, rem_sel_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;

  muldivOp_t         op;
  logic [2*XLEN-1:0] prod_u;
  logic [XLEN-1:0]   prod_hi;
  logic              mul_a_signed, mul_b_signed;
  logic              div_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   div_quot, div_rem, quot_fix, rem_fix;
  logic              div_load, div_step, div_last, accept;

  assign op           = muldivOp_t'(funct3);
  assign mul_a_signed = (op == OP_MULH) || (op == OP_MULHSU);
  assign mul_b_signed = (op == OP_MULH);

  // Signed high word = unsigned high word minus the cross terms of negative operands.
  assign prod_u  = {{XLEN{1'b0}}, opA} * {{XLEN{1'b0}}, opB};
  assign prod_hi = prod_u[2*XLEN-1:XLEN]
                 - ((mul_a_signed && opA[XLEN-1]) ? opB : '0)
                 - ((mul_b_signed && opB[XLEN-1]) ? opA : '0);

  assign div_signed = funct3[2] && !funct3[0];
  assign a_neg      = div_signed && opA[XLEN-1];
  assign b_neg      = div_signed && opB[XLEN-1];
  assign a_mag      = a_neg ? -opA : opA;
  assign b_mag      = b_neg ? -opB : opB;

  assign quot_fix = neg_quot_q ? -div_quot : div_quot;
  assign rem_fix  = neg_rem_q  ? -div_rem  : div_rem;

  assign accept = start && !flush && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    rem_sel_d  = rem_sel_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div_load   = 1'b0;
    div_step   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          rem_sel_d  = funct3[1];
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          state_d    = DONE;
          if (!funct3[2]) begin
            result_d = (op == OP_MUL) ? prod_u[XLEN-1:0] : prod_hi;
          end else if (opB == '0) begin
            result_d = funct3[1] ? opA : ALL_ONES;
          end else if (div_signed && (opA == INT_MIN) && (opB == ALL_ONES)) begin
            result_d = funct3[1] ? '0 : INT_MIN;
          end else begin
            div_load = 1'b1;
            state_d  = DIV;
          end
        end
      end
      DIV: begin
        div_step = 1'b1;
        if (div_last) state_d = FIX;
      end
      FIX: begin
        result_d = rem_sel_q ? rem_fix : quot_fix;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    // An abort discards the op in flight and leaves the last result visible.
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q    <= IDLE;
      result_q   <= '0;
      rem_sel_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      rem_sel_q  <= rem_sel_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  divCore #(.W(XLEN)) u_div (
    .clk        (clk),
    .rstN       (rstN),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .last_o     (div_last),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  assign busy   = (state_q == DIV) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: arithmetic reference model checked every cycle,
// plus literal expectations on latency and result per transaction.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  exe_muldiv #(.XLEN(32)) dut (
    .clk    (clk),
    .rstN   (rstN),
    .start  (start),
    .funct3 (funct3),
    .opA    (opA),
    .opB    (opB),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference result from plain RV32M arithmetic rules.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic   ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return !f[2] || (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Cycle model: m_left counts cycles until the done cycle of a long divide.
  int          m_left = 0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pending = '0;

  always @(posedge clk) begin
    bit was_busy;
    was_busy = m_busy;
    if (!rstN) begin
      m_left = 0; m_busy = 0; m_done = 0; m_res = '0;
    end else begin
      m_done = 0;
      m_busy = 0;
      if (flush) begin
        m_left = 0;
      end else if (start && !was_busy) begin
        if (is_fast(funct3, opA, opB)) begin
          m_done = 1;
          m_res  = ref_op(funct3, opA, opB);
          m_left = 0;
        end else begin
          m_pending = ref_op(funct3, opA, opB);
          m_left    = 33;
          m_busy    = 1;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_res  = m_pending;
        end else begin
          m_busy = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
    chk("cyc_done", {31'd0, done}, {31'd0, m_done});
    chk("cyc_result", result, m_res);
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input int exp_busy,
                        input logic [31:0] exp_res);
    int lat, nb;
    @(negedge clk);
    start = 1'b1; funct3 = f; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0; opA = 32'hA5A5_5A5A; opB = 32'h5A5A_A5A5;
    lat = 1; nb = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_busy_cycles"}, nb, exp_busy);
    chk({name, "_res"}, result, exp_res);
    $display("op %-8s f=%0d a=%h b=%h -> result=%h lat=%0d busy=%0d", name, f, a, b, result, lat, nb);
  endtask

  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rstN = 1'b1;

    run_op("MULH",   3'd1, 32'hFFFF_FFFF, 32'h2, 1, 0, 32'hFFFF_FFFF);
    run_op("MUL",    3'd0, 32'hFFFF_FFFF, 32'h2, 1, 0, 32'hFFFF_FFFE);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF);
    run_op("MULHU",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFE);
    run_op("DIV",    3'd4, 32'hFFFF_FFF9, 32'h2, 34, 33, 32'hFFFF_FFFD);
    run_op("REM",    3'd6, 32'hFFFF_FFF9, 32'h2, 34, 33, 32'hFFFF_FFFF);
    run_op("DIVm",   3'd4, 32'hFFFF_FF9C, 32'h7, 34, 33, 32'hFFFF_FFF2);
    run_op("REMm",   3'd6, 32'hFFFF_FF9C, 32'h7, 34, 33, 32'hFFFF_FFFE);
    run_op("REMn",   3'd6, 32'd100, 32'hFFFF_FFF9, 34, 33, 32'h2);
    run_op("DIVU0",  3'd5, 32'd55, 32'h0, 1, 0, 32'hFFFF_FFFF);
    run_op("REMovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h0);
    run_op("DIVovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h8000_0000);
    run_op("REMU0",  3'd7, 32'h1234, 32'h0, 1, 0, 32'h1234);

    // flush beats a simultaneous start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; opA = 32'd3; opB = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flushstart_done", {31'd0, done}, 32'd0);
    chk("flushstart_res", result, 32'h1234);

    // DIVU 100/7 aborted at N+10
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; opA = 32'd100; opB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) cnt++;
      @(negedge clk);
    end
    chk("flush_no_done", cnt, 0);
    chk("flush_res_kept", result, 32'h1234);
    $display("flush DIVU 100/7 aborted, result=%h", result);
    run_op("REMU", 3'd7, 32'd100, 32'd7, 34, 33, 32'h2);

    // start held high through a divide, then back-to-back MUL in the DONE cycle
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; opA = 32'd1000; opB = 32'd10;
    @(negedge clk);
    cnt = 1;
    while (done !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("held_lat", cnt, 34);
    chk("held_res", result, 32'd100);
    funct3 = 3'd0; opA = 32'd6; opB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_res", result, 32'd42);
    $display("held DIVU 1000/10 then MUL 6*7 -> result=%h", result);

    // reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; opA = 32'd77; opB = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_res", result, 32'd0);
    $display("reset mid-divide -> busy=%b done=%b result=%h", busy, done, result);
    rstN = 1'b1;
    run_op("DIVpost", 3'd4, 32'd77, 32'd5, 34, 33, 32'd15);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

RV32M multiply/divide unit for the execute stage. Accepts an M-extension op with both register operands, produces a 32-bit result that the execute stage places on the ALU-result path feeding the data-memory/writeback stage. Multiplies complete in one cycle; divides and remainders run iteratively, and `busy` stalls the front of the pipeline meanwhile.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rstN`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only when the unit can accept (IDLE or DONE).
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `opA`  in  32  rs1 value (dividend / multiplicand).
- `opB`  in  32  rs2 value (divisor / multiplier).
- `flush`  in  1  synchronous abort from branch/trap redirect.
- `busy`  out  1  an accepted op has not yet produced its result; the pipeline stalls.
- `done`  out  1  one-cycle pulse; `result` valid this cycle.
- `result`  out  32  op result; holds its value until the next `done`.

## Operation
- States: IDLE, DIV, FIX, DONE.
- Accept: `start`=1 in IDLE or DONE, and `flush`=0. Latch `funct3`, `opA`, `opB`. `start` in DIV/FIX is ignored.
- MUL group: full 64-bit product of the sign-/zero-extended operands, written directly into `result` at the accept edge.
  - MUL returns the low 32 bits.
  - MULH, MULHSU and MULHU return the high 32 bits.
  - MULHSU treats `opA` as signed and `opB` as unsigned.
  - State goes to DONE.
- Divide special cases are resolved at the accept edge and go straight to DONE:
  - `opB`=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `opA`.
  - DIV/REM with `opA`=0x80000000 and `opB`=0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.
- General divide:
  - Signed ops take magnitudes of both operands.
  - Restoring division produces one quotient bit per cycle for 32 cycles in DIV, using a 5-bit down-counter from 31 to 0.
  - FIX then applies signs: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - FIX selects quotient or remainder into `result` and moves to DONE.
- DONE → IDLE, or re-accepts if `start`=1 (back-to-back).
- `flush`=1:
  - Next state IDLE; `busy` and `done` are 0 from the next cycle.
  - `result` is not updated.
  - `flush` beats a simultaneous `start`.
- Reset (`rstN`=0 at an edge): state IDLE, `busy`=0, `done`=0, `result`=0. This applies mid-divide too.

## Timing
- Let N be the cycle in which `start` is accepted.
- MUL group and divide special cases:
  - `done`=1 in cycle N+1.
  - `busy` is never asserted.
- General divide:
  - `busy`=1 in cycles N+1 through N+33 (DIV×32, FIX×1).
  - `done`=1 with `busy`=0 in cycle N+34.
- `busy` is a registered output equal to (state ∈ {DIV, FIX}).
- `done` is a registered output equal to (state == DONE).
- Operand inputs need only be stable in cycle N.

## Structure
- Package `muldivPkg` holds:
  - `muldivOp_t`, an enum over the eight `funct3` encodings.
  - `mdState_t` (IDLE, DIV, FIX, DONE).
  - Constants `DIV_ITERS`=32, `ALL_ONES`, `INT_MIN`.
- Sub-module `divCore`: unsigned iterative restoring divider, containing the remainder/quotient shift registers and counter.
- The top level owns the FSM, the multiplier, special-case detection and sign fix-up.

## Test plan
- MULH, `opA`=0xFFFFFFFF (−1), `opB`=0x00000002 → `done` at N+1, `result`=0xFFFFFFFF; MUL with the same operands → 0xFFFFFFFE.
- MULHSU, `opA`=0xFFFFFFFF, `opB`=0xFFFFFFFF → 0xFFFFFFFF; MULHU with the same operands → 0xFFFFFFFE.
- DIV, `opA`=0xFFFFFFF9 (−7), `opB`=2:
  - `busy` is high for exactly 33 cycles, then `done` at N+34 with `result`=0xFFFFFFFD (−3).
  - REM with the same operands → 0xFFFFFFFF (−1).
- DIVU with `opB`=0 → 0xFFFFFFFF at N+1; REM with `opA`=0x80000000, `opB`=0xFFFFFFFF → 0 at N+1.
- DIVU 100/7 started, `flush` at N+10 → `busy` is 0 at N+11, no `done`, `result` unchanged; a new REMU 100/7 then returns 2.
- `start` held high through a DIVU (ignored while busy), then back-to-back MUL accepted in the DONE cycle → next `done` one cycle later; `rstN`=0 mid-divide → all outputs 0 the following cycle.
